add_share_arbiter: RTL and testbench
====================================

Name: add_share_arbiter

Overview:
Shares one WIDTH-bit adder datapath (sum of two operands, with carry) between NREQ requesters. A round-robin arbiter picks one valid request per cycle. The winning operands are added into a one-deep registered result stage, which carries a valid/ready handshake and a requester tag. The block sits between the input-decoding logic and the uo_out/uio driver logic of the tile top.

Parameters:
WIDTH, 8, operand and sum width in bits
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ) (min 1), width of requester tag

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  accept enable; 0 blocks new accepts
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept (one-hot or zero)
req_a  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  operand B, same packing
res_valid  output  1  result register holds unconsumed result
res_ready  input  1  consumer accepts result
res_sum  output  WIDTH  (a+b) mod 2^WIDTH
res_carry  output  1  carry-out of a+b
res_id  output  IDW  index of requester that produced the result
busy  output  1  res_valid | (|req_valid)

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low on rst_n.
- Reset values: res_valid=0, res_sum=0, res_carry=0, res_id=0. last_grant=NREQ-1, so requester 0 has top priority first. req_ready=0 while in reset.
- can_accept = ena & (~res_valid | res_ready). The output stage accepts when empty, or when draining in the same cycle.
- Grant (combinational):
  - Scan requesters starting at (last_grant+1) mod NREQ, wrapping around.
  - The first i with req_valid[i] is granted.
  - req_ready[i] = can_accept & grant[i].
  - At most one bit of req_ready is set.
- Requester rule: a requester must not make req_valid depend on req_ready. Once asserted, req_valid and the operands are held until accepted.
- Transfer: a transfer occurs when req_valid[i] & req_ready[i]. On the next clk edge:
  - res_valid=1
  - {res_carry,res_sum} = req_a[i] + req_b[i], computed at WIDTH+1 bits
  - res_id=i
  - last_grant=i
- Latency is 1 cycle from transfer to res_valid. Throughput is one result per cycle when res_ready is held at 1.
- Drain without a new transfer: res_valid=1 & res_ready=1 clears res_valid on the next edge. res_sum, res_carry and res_id keep their last values.
- Stall: res_valid=1 & res_ready=0 holds all result outputs stable and forces req_ready=0.
- Simultaneous drain and accept: the new result replaces the old one on the same edge. res_valid stays 1, with no bubble.
- last_grant changes only on a transfer. Idle cycles and stalls do not rotate priority.
- ena=0:
  - req_ready=0, so no new transfers.
  - A pending result can still drain via res_ready.
  - Arbitration state is held.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). Any in-flight result is discarded.
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once per NREQ transfers.

Decomposition:
- Shared package add_share_pkg holds:
  - default WIDTH and NREQ localparams
  - clog2-based IDW helper
  - typedef of the result struct {carry, sum, id}
- One sub-module, rr_arbiter:
  - inputs: req vector, advance strobe (= transfer), clk, rst_n
  - outputs: one-hot grant and encoded grant index
  - owns last_grant
- The adder and result register stay in add_share_arbiter.

Test Plan:
1. Reset: assert rst_n=0 asynchronously while res_valid=1, between clock edges -> res_valid, res_sum, res_carry and res_id go to 0 immediately. After release, with only req0 valid, req_ready[0]=1.
2. Arithmetic:
   - req2 alone, a=0x7F b=0x01 -> next cycle res_valid=1, sum=0x80, carry=0, id=2.
   - a=0xFF b=0x02 -> sum=0x01, carry=1.
   - a=0xFF b=0xFF -> sum=0xFE, carry=1.
3. Round-robin: all four valid, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, res_id follows one cycle later, with no idle cycles.
4. Priority after gap: grant req1, then only req0 and req3 valid -> req3 is granted first, then req0.
5. Backpressure:
   - res_valid=1 with res_ready=0 for 3 cycles -> req_ready=0 and outputs stable for all 3 cycles.
   - Raise res_ready with req1 pending -> drain and accept in the same cycle, res_valid stays 1, id=1 on the next cycle.
6. ena: ena=0 with req0 valid and one result pending -> req_ready=0, the pending result drains when res_ready=1, then res_valid=0. Set ena=1 -> req0 is accepted in that cycle.

Source files
------------

// File: rtl/add_share_pkg.sv
// -----------------------------------------------------------------------------
// add_share_pkg
//   Shared definitions for the shared-adder arbiter block:
//     - default operand width and requester count
//     - requester-tag width helper (clog2 with a floor of 1 bit)
//     - result record {carry, sum, id} at the default configuration
// -----------------------------------------------------------------------------
package add_share_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_NREQ  = 4;

   // Tag width for n requesters; never narrower than one bit so the tag
   // port stays legal when n is 1 or 2.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_IDW = id_width(DEFAULT_NREQ);

   // Result record as seen by the downstream driver logic.
   typedef struct packed {
      logic                     carry;
      logic [DEFAULT_WIDTH-1:0] sum;
      logic [DEFAULT_IDW-1:0]   id;
   } res_t;

endpackage : add_share_pkg

// File: rtl/add_share_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. Scans requesters starting one past the last granted
//   index and wraps around; the first active request wins. Priority rotates
//   only when the caller reports that the grant was actually used.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   req_i       in   [NREQ]  request vector
//   advance_i   in   grant was consumed this cycle; commit it as last grant
//   grant_o     out  [NREQ]  one-hot grant (zero when no request)
//   grant_idx_o out  [IDW]   encoded index of grant_o (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
   import add_share_pkg::*;
#(
   parameter int NREQ = DEFAULT_NREQ,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            advance_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  grant_idx_o
);

   logic [IDW-1:0] last_grant_q;
   logic [IDW-1:0] last_grant_d;

   // Scan order: last+1, last+2, ... last+NREQ (the last one is itself).
   always_comb begin
      // NOTE: every output of a combinational block gets a default before
      // any conditional assignment; a path that leaves one unassigned would
      // infer a latch.
      grant_o     = '0;
      grant_idx_o = '0;
      for (int off = 1; off <= NREQ; off++) begin
         int idx;
         idx = (int'(last_grant_q) + off) % NREQ;
         if ((grant_o == '0) && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            grant_idx_o  = IDW'(idx);
         end
      end
   end

   // Priority only moves on a real transfer; idle and stalled cycles keep it.
   assign last_grant_d = advance_i ? grant_idx_o : last_grant_q;

   // Reset to NREQ-1 so requester 0 is first in line after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= IDW'(NREQ - 1);
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // flop samples the pre-edge value, independent of statement order.
         last_grant_q <= last_grant_d;
      end
   end

endmodule : rr_arbiter

// File: rtl/add_share_arbiter.sv
// -----------------------------------------------------------------------------
// add_share_arbiter
//   One WIDTH-bit adder shared by NREQ requesters. A round-robin arbiter picks
//   one valid request per cycle; the winner's a+b (with carry) is captured in a
//   one-deep result register carrying a valid/ready handshake and the
//   requester tag. A full result register that is being drained can accept a
//   new result on the same edge, so throughput is one result per cycle.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   accept enable; 0 blocks new transfers (drain still works)
//   req_valid  in   [NREQ]        per-requester request valid
//   req_ready  out  [NREQ]        per-requester accept, one-hot or zero
//   req_a      in   [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NREQ*WIDTH]  operand B, same packing
//   res_valid  out  result register holds an unconsumed result
//   res_ready  in   consumer takes the result this cycle
//   res_sum    out  [WIDTH]  (a+b) mod 2^WIDTH
//   res_carry  out  carry-out of a+b
//   res_id     out  [IDW]    index of the requester that produced the result
//   busy       out  res_valid | any req_valid
// -----------------------------------------------------------------------------
module add_share_arbiter
   import add_share_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int NREQ  = DEFAULT_NREQ,
   parameter int IDW   = id_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_sum,
   output logic                  res_carry,
   output logic [IDW-1:0]        res_id,
   output logic                  busy
);

   // Same layout as add_share_pkg::res_t, sized by this instance's parameters.
   typedef struct packed {
      logic             carry;
      logic [WIDTH-1:0] sum;
      logic [IDW-1:0]   id;
   } result_t;

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             can_accept;
   logic             transfer;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   full_sum;

   logic             res_valid_q;
   logic             res_valid_d;
   result_t          res_q;
   result_t          res_d;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arbiter (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req_valid),
      .advance_i   (transfer),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Output stage has room when empty or being drained this cycle. rst_n is
   // folded in so no requester sees an accept while the block is in reset.
   assign can_accept = rst_n & ena & (~res_valid_q | res_ready);
   assign req_ready  = grant & {NREQ{can_accept}};
   assign transfer   = |(req_valid & req_ready);

   // ---------------------------------------------------------------------------
   // Shared adder: AND-OR operand mux driven by the one-hot grant
   // ---------------------------------------------------------------------------
   always_comb begin
      op_a = '0;
      op_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            op_a = op_a | req_a[i*WIDTH +: WIDTH];
            op_b = op_b | req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign full_sum = {1'b0, op_a} + {1'b0, op_b};

   // ---------------------------------------------------------------------------
   // Result register
   // ---------------------------------------------------------------------------
   // A transfer always loads (covers drain-and-accept with no bubble); a drain
   // without a transfer only clears valid and leaves the payload in place.
   always_comb begin
      res_valid_d = res_valid_q;
      res_d       = res_q;
      if (transfer) begin
         res_valid_d = 1'b1;
         res_d.carry = full_sum[WIDTH];
         res_d.sum   = full_sum[WIDTH-1:0];
         res_d.id    = grant_idx;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the payload is reset as well as valid, because its value is
         // directly visible on res_sum/res_carry/res_id and must read as zero
         // out of reset.
         res_valid_q <= 1'b0;
         res_q       <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_q       <= res_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_sum   = res_q.sum;
   assign res_carry = res_q.carry;
   assign res_id    = res_q.id;
   assign busy      = res_valid_q | (|req_valid);

endmodule : add_share_arbiter

// File: tb/tb_add_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_share_arbiter
//   Directed, self-checking bench for add_share_arbiter at WIDTH=8, NREQ=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled after a
//   further settle delay, well clear of the active edge.
// -----------------------------------------------------------------------------
module tb_add_share_arbiter;
   import add_share_pkg::*;

   localparam int W  = DEFAULT_WIDTH;
   localparam int N  = DEFAULT_NREQ;
   localparam int IW = DEFAULT_IDW;

   logic            clk;
   logic            rst_n;
   logic            ena;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic            res_valid;
   logic            res_ready;
   logic [W-1:0]    res_sum;
   logic            res_carry;
   logic [IW-1:0]   res_id;
   logic            busy;

   int n_checks = 0;
   int n_errors = 0;

   add_share_arbiter #(
      .WIDTH (W),
      .NREQ  (N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_carry (res_carry),
      .res_id    (res_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Compares the full visible result record against an expected one.
   task automatic check_res(input string tag, input res_t exp);
      check({tag, ".valid"}, 32'(res_valid), 32'd1);
      check({tag, ".sum"},   32'(res_sum),   32'(exp.sum));
      check({tag, ".carry"}, 32'(res_carry), 32'(exp.carry));
      check({tag, ".id"},    32'(res_id),    32'(exp.id));
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // Advance past the next rising edge; inputs may be driven right after.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   initial begin
      res_t exp;

      rst_n     = 1'b0;
      ena       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;

      // ---------------- Reset state ----------------
      req_valid = 4'b0001;
      set_req(0, 8'h11, 8'h22);
      settle();
      check("rst.res_valid", 32'(res_valid), 32'd0);
      check("rst.res_sum",   32'(res_sum),   32'd0);
      check("rst.res_id",    32'(res_id),    32'd0);
      check("rst.req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle.busy", 32'(busy), 32'd0);

      // ---------------- Arithmetic, requester 2 ----------------
      req_valid = 4'b0100;
      set_req(2, 8'h7F, 8'h01);
      settle();
      check("ar1.req_ready", 32'(req_ready), 32'b0100);
      check("ar1.busy",      32'(busy),      32'd1);
      tick();
      exp = '{carry: 1'b0, sum: 8'h80, id: 2'd2};
      check_res("ar1", exp);

      res_ready = 1'b1;
      set_req(2, 8'hFF, 8'h02);
      settle();
      check("ar2.req_ready", 32'(req_ready), 32'b0100);
      tick();
      exp = '{carry: 1'b1, sum: 8'h01, id: 2'd2};
      check_res("ar2", exp);

      set_req(2, 8'hFF, 8'hFF);
      tick();
      exp = '{carry: 1'b1, sum: 8'hFE, id: 2'd2};
      check_res("ar3", exp);

      // Drain with no new transfer: valid drops, payload is kept.
      req_valid = '0;
      tick();
      check("drain.res_valid", 32'(res_valid), 32'd0);
      check("drain.res_sum",   32'(res_sum),   32'hFE);
      check("drain.res_carry", 32'(res_carry), 32'd1);

      // ---------------- Asynchronous reset mid-operation ----------------
      res_ready = 1'b0;
      req_valid = 4'b0001;
      set_req(0, 8'h03, 8'h04);
      tick();
      exp = '{carry: 1'b0, sum: 8'h07, id: 2'd0};
      check_res("pre_rst", exp);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.res_valid", 32'(res_valid), 32'd0);
      check("arst.res_sum",   32'(res_sum),   32'd0);
      check("arst.res_carry", 32'(res_carry), 32'd0);
      check("arst.res_id",    32'(res_id),    32'd0);
      check("arst.req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      settle();
      // last_grant back to 3, so requester 0 is granted even alongside 3.
      req_valid = 4'b1001;
      settle();
      check("post_rst.req_ready", 32'(req_ready), 32'b0001);

      // ---------------- Round-robin with all four requesting ----------------
      res_ready = 1'b1;
      req_valid = 4'b1111;
      for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 * i + 1), 8'(i));
      settle();
      for (int k = 0; k < 6; k++) begin
         int g;
         g = k % N;
         check($sformatf("rr%0d.req_ready", k), 32'(req_ready), 32'(1 << g));
         tick();
         exp = '{carry: 1'b0, sum: 8'(8'h10 * g + 1 + g), id: 2'(g)};
         check_res($sformatf("rr%0d", k), exp);
      end

      // ---------------- Priority after gap (last grant = 1) ----------------
      req_valid = 4'b1001;
      set_req(0, 8'hA0, 8'h0A);
      set_req(3, 8'h30, 8'h03);
      settle();
      check("gap1.req_ready", 32'(req_ready), 32'b1000);
      tick();
      exp = '{carry: 1'b0, sum: 8'h33, id: 2'd3};
      check_res("gap1", exp);
      req_valid = 4'b0001;
      settle();
      check("gap2.req_ready", 32'(req_ready), 32'b0001);
      tick();
      exp = '{carry: 1'b0, sum: 8'hAA, id: 2'd0};
      check_res("gap2", exp);
      req_valid = '0;
      tick();
      check("gap.drain", 32'(res_valid), 32'd0);

      // ---------------- Backpressure (last grant = 0) ----------------
      res_ready = 1'b0;
      req_valid = 4'b0001;
      set_req(0, 8'h10, 8'h20);
      tick();
      req_valid = 4'b0010;
      set_req(1, 8'h40, 8'h05);
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("stall%0d.req_ready", k), 32'(req_ready), 32'd0);
         exp = '{carry: 1'b0, sum: 8'h30, id: 2'd0};
         check_res($sformatf("stall%0d", k), exp);
         tick();
      end
      res_ready = 1'b1;
      settle();
      check("unstall.req_ready", 32'(req_ready), 32'b0010);
      tick();
      exp = '{carry: 1'b0, sum: 8'h45, id: 2'd1};
      check_res("unstall", exp);
      req_valid = '0;
      tick();
      check("bp.drain", 32'(res_valid), 32'd0);

      // ---------------- ena gating (last grant = 1) ----------------
      res_ready = 1'b0;
      req_valid = 4'b0001;
      set_req(0, 8'h01, 8'h01);
      tick();
      exp = '{carry: 1'b0, sum: 8'h02, id: 2'd0};
      check_res("ena.pend", exp);
      ena = 1'b0;
      set_req(0, 8'h05, 8'h06);
      settle();
      check("ena0.req_ready", 32'(req_ready), 32'd0);
      res_ready = 1'b1;
      settle();
      check("ena0_drain.req_ready", 32'(req_ready), 32'd0);
      tick();
      check("ena0.res_valid_a", 32'(res_valid), 32'd0);
      check("ena0.busy",        32'(busy),      32'd1);
      tick();
      check("ena0.res_valid_b", 32'(res_valid), 32'd0);
      check("ena0.res_sum",     32'(res_sum),   32'h02);
      ena = 1'b1;
      settle();
      check("ena1.req_ready", 32'(req_ready), 32'b0001);
      tick();
      exp = '{carry: 1'b0, sum: 8'h0B, id: 2'd0};
      check_res("ena1", exp);
      req_valid = '0;
      tick();
      check("end.res_valid", 32'(res_valid), 32'd0);
      check("end.busy",      32'(busy),      32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_add_share_arbiter
